// File: rtl/uart2wb_pkg.sv
// Shared constants and parser state encoding for the UART-to-Wishbone bridge master.
package uart2wb_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } parse_state_e;

endpackage

// File: rtl/uart2wb_uart.sv
// 8N1 UART: synchronized receiver with framing-error flag, and a transmitter that
// accepts the next byte during the final stop-bit cycle so responses go out back-to-back.
module uart2wb_uart #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);

  logic             rxd_s1, rxd_s2, rxd_d;
  logic             rx_active;
  logic [DIV_W-1:0] rx_div;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_tick;

  // rx_bit 0 is the start-bit recheck at half a bit; 1..8 data; 9 stop
  assign rx_tick = (rx_bit == 4'd0) ? (rx_div == HALF_LAST) : (rx_div == DIV_LAST);
  assign rx_data = rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_d     <= 1'b1;
      rx_active <= 1'b0;
      rx_div    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_d    <= rxd_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rxd_d && !rxd_s2) begin
          rx_active <= 1'b1;
          rx_div    <= '0;
          rx_bit    <= '0;
        end
      end else if (!rx_tick) begin
        rx_div <= rx_div + 1'b1;
      end else begin
        rx_div <= '0;
        if (rx_bit == 4'd0) begin
          if (rxd_s2) rx_active <= 1'b0;
          else        rx_bit    <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          rx_valid  <= rxd_s2;
          rx_ferr   <= !rxd_s2;
        end else begin
          rx_sh  <= {rxd_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end
    end
  end

  logic             tx_active;
  logic [DIV_W-1:0] tx_div;
  logic [3:0]       tx_bit;
  logic [9:0]       tx_sh;
  logic             tx_last;
  logic             tx_load;

  assign tx_last = tx_active && (tx_bit == 4'd9) && (tx_div == DIV_LAST);
  assign tx_load = tx_start && (!tx_active || tx_last);
  assign tx_busy = tx_active && !tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_div    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
      txd       <= 1'b1;
    end else if (tx_load) begin
      tx_sh     <= {1'b1, tx_data, 1'b0};
      tx_active <= 1'b1;
      tx_div    <= '0;
      tx_bit    <= '0;
      txd       <= 1'b0;
    end else if (tx_active) begin
      if (tx_div == DIV_LAST) begin
        tx_div <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
          txd       <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx_sh  <= {1'b1, tx_sh[9:1]};
          txd    <= tx_sh[1];
        end
      end else begin
        tx_div <= tx_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart2wb_master.sv
// UART command parser driving single Wishbone classic transfers, with a timeout
// and a serial response sequencer ('K', 'E' or four read-data bytes).
module uart2wb_master
  import uart2wb_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int WB_TIMEOUT = 256
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_n,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);

  localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WB_TIMEOUT - 1);

  parse_state_e state, state_nxt;

  logic [7:0]       rx_data;
  logic             rx_valid, rx_ferr;
  logic             tx_start, tx_busy;
  logic [1:0]       byte_cnt;
  logic             we_r;
  logic [31:0]      adr_r, dat_r;
  logic [31:0]      rsp_buf;
  logic [2:0]       rsp_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             is_cmd;

  uart2wb_uart #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk      (wbm_clk_i),
    .rst_n    (wbm_rst_n),
    .rxd      (uart_rxd_i),
    .txd      (uart_txd_o),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .tx_data  (rsp_buf[31:24]),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  assign is_cmd  = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign wbm_cyc_o = (state == ST_BUS);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign wbm_we_o  = we_r;
  assign busy_o    = (state == ST_BUS) || (state == ST_RESP);

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid && is_cmd) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (rx_ferr)                            state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_nxt = we_r ? ST_DATA : ST_BUS;
      end
      ST_DATA: begin
        if (rx_ferr)                            state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_nxt = ST_BUS;
      end
      ST_BUS:  if (wbm_err_i || wbm_ack_i || tmo_hit) state_nxt = ST_RESP;
      ST_RESP: begin
        tx_start = (rsp_cnt != 3'd0) && !tx_busy;
        // tx_busy drops in the last stop-bit cycle, so busy_o ends with the stop bit
        if (rsp_cnt == 3'd0 && !tx_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      byte_cnt <= '0;
      we_r     <= 1'b0;
      adr_r    <= '0;
      dat_r    <= '0;
      rsp_buf  <= '0;
      rsp_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid && is_cmd) begin
            we_r     <= (rx_data == CMD_WR);
            byte_cnt <= '0;
          end
        end
        ST_ADDR: if (rx_valid) begin
          adr_r    <= {adr_r[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        ST_DATA: if (rx_valid) begin
          dat_r    <= {dat_r[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        ST_BUS: begin
          // err has priority over a simultaneous ack
          if (wbm_err_i || (!wbm_ack_i && tmo_hit)) begin
            rsp_buf <= {RSP_ERR, 24'h0};
            rsp_cnt <= 3'd1;
          end else if (wbm_ack_i) begin
            rsp_buf <= we_r ? {RSP_OK, 24'h0} : wbm_dat_i;
            rsp_cnt <= we_r ? 3'd1 : 3'd4;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          tmo_cnt <= '0;
          if (tx_start) begin
            rsp_buf <= {rsp_buf[23:0], 8'h00};
            rsp_cnt <= rsp_cnt - 3'd1;
          end
        end
        default: tmo_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart2wb_master.sv
// Bench for uart2wb_master: serial frames in, Wishbone slave model, bus and TX scoreboards.
module tb_uart2wb_master;

  localparam int CLK_DIV    = 16;
  localparam int WB_TIMEOUT = 256;
  localparam int S_ACK      = 0;
  localparam int S_NONE     = 1;
  localparam int S_ACKERR   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rxd = 1'b1;
  logic        uart_txd_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  always #5 clk = ~clk;

  uart2wb_master #(.CLK_DIV(CLK_DIV), .WB_TIMEOUT(WB_TIMEOUT)) dut (
    .wbm_clk_i  (clk),
    .wbm_rst_n  (rst_n),
    .uart_rxd_i (rxd),
    .uart_txd_o (uart_txd_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .busy_o     (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] mem [bit [31:0]];

  int s_mode = S_ACK;
  int s_lat  = 1;
  int wait_cnt = 0;
  int cyc_len = 0;
  int last_cyc_len = 0;
  int xfer_cnt = 0;
  bit in_xfer = 1'b0;
  bit mon_en = 1'b0;

  // Wishbone slave model, driven on the falling edge
  always @(negedge clk) begin : slave
    bus_t e;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom();
    if (rst_n && wbm_cyc_o) begin
      if (!in_xfer) begin
        in_xfer  = 1'b1;
        wait_cnt = 0;
        cyc_len  = 0;
        chk("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
        chk("busy_in_bus", 32'(busy_o), 32'd1);
        chk("stb_eq_cyc", 32'(wbm_stb_o), 32'd1);
        chk("sel", 32'(wbm_sel_o), 32'hF);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          chk("bus_adr", wbm_adr_o, e.adr);
          chk("bus_we", 32'(wbm_we_o), 32'(e.we));
          if (e.we) chk("bus_dat", wbm_dat_o, e.dat);
        end
      end
      cyc_len++;
      if (s_mode == S_ACK && wait_cnt == s_lat) begin
        wbm_ack_i = 1'b1;
        if (wbm_we_o) mem[wbm_adr_o] = wbm_dat_o;
        wbm_dat_i = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'h0;
      end else if (s_mode == S_ACKERR && wait_cnt == s_lat) begin
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
      end
      wait_cnt++;
    end else if (in_xfer) begin
      in_xfer      = 1'b0;
      last_cyc_len = cyc_len;
      xfer_cnt++;
    end
  end

  // Serial response monitor
  always begin : tx_mon
    logic [7:0] b;
    logic       st, sp;
    @(negedge uart_txd_o);
    repeat (CLK_DIV / 2) @(posedge clk);
    #1 st = uart_txd_o;
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(posedge clk);
      #1 b[i] = uart_txd_o;
    end
    repeat (CLK_DIV) @(posedge clk);
    #1 sp = uart_txd_o;
    if (mon_en) begin
      chk("tx_start_bit", 32'(st), 32'd0);
      chk("tx_stop_bit", 32'(sp), 32'd1);
      chk("tx_pending", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    if (!stop_bit) repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(cmd, 1'b1);
    send_word(adr);
    if (cmd == 8'h57) send_word(dat);
  endtask

  task automatic expect_bus(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bus_t e;
    e.adr = adr;
    e.we  = we;
    e.dat = dat;
    exp_bus.push_back(e);
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      if (exp_tx.size() == 0 && !busy_o) break;
      @(posedge clk);
    end
    #1 chk("resp_done", 32'((exp_tx.size() != 0) || busy_o), 32'd0);
    chk("bus_consumed", 32'(exp_bus.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat);
    expect_bus(adr, 1'b1, dat);
    exp_tx.push_back(8'h4B);
    send_frame(8'h57, adr, dat);
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [31:0] dat);
    expect_bus(adr, 1'b0, 32'h0);
    expect_word(dat);
    send_frame(8'h52, adr, 32'h0);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_txd"},  32'(uart_txd_o), 32'd1);
    chk({pfx, "_cyc"},  32'(wbm_cyc_o), 32'd0);
    chk({pfx, "_stb"},  32'(wbm_stb_o), 32'd0);
    chk({pfx, "_we"},   32'(wbm_we_o), 32'd0);
    chk({pfx, "_adr"},  wbm_adr_o, 32'h0);
    chk({pfx, "_dat"},  wbm_dat_o, 32'h0);
    chk({pfx, "_sel"},  32'(wbm_sel_o), 32'h0);
    chk({pfx, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #(900_000 * 10);
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    mon_en = 1'b1;

    // write then read back, two locations
    s_mode = S_ACK; s_lat = 1;
    do_write(32'h3000_0000, 32'h1122_3344);
    do_read (32'h3000_0000, 32'h1122_3344);
    do_write(32'h3000_0004, 32'h5566_7788);
    do_read (32'h3000_0004, 32'h5566_7788);

    // no response from the slave: abort after WB_TIMEOUT cycles
    s_mode = S_NONE;
    expect_bus(32'h4000_0000, 1'b0, 32'h0);
    exp_tx.push_back(8'h45);
    send_frame(8'h52, 32'h4000_0000, 32'h0);
    wait_done();
    chk("timeout_cycles", 32'(last_cyc_len), 32'(WB_TIMEOUT));

    // ack and err together
    s_mode = S_ACKERR; s_lat = 0;
    expect_bus(32'h3000_0010, 1'b1, 32'h0000_0099);
    exp_tx.push_back(8'h45);
    send_frame(8'h57, 32'h3000_0010, 32'h0000_0099);
    wait_done();

    // non-command bytes in IDLE
    n0 = xfer_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("idle_no_bus", 32'(xfer_cnt - n0), 32'd0);

    // framing error on address byte 2, then a clean write
    s_mode = S_ACK; s_lat = 1;
    n0 = xfer_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b0);
    do_write(32'h3000_0008, 32'hCAFE_F00D);
    chk("ferr_one_xfer", 32'(xfer_cnt - n0), 32'd1);
    do_read(32'h3000_0008, 32'hCAFE_F00D);

    // reset while cyc is high
    s_mode = S_NONE;
    expect_bus(32'h5000_0000, 1'b0, 32'h0);
    send_frame(8'h52, 32'h5000_0000, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      if (wbm_cyc_o) break;
      @(posedge clk);
    end
    #1 chk("cyc_before_reset", 32'(wbm_cyc_o), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_outputs("rst_bus");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a read response
    s_mode = S_ACK;
    mon_en = 1'b0;
    expect_bus(32'h3000_0000, 1'b0, 32'h0);
    send_frame(8'h52, 32'h3000_0000, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      if (!uart_txd_o) break;
      @(posedge clk);
    end
    #1 chk("tx_before_reset", 32'(uart_txd_o), 32'd0);
    repeat (15 * CLK_DIV) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_outputs("rst_tx");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    mon_en = 1'b1;

    do_write(32'h3000_000C, 32'h0A0B_0C0D);
    do_read (32'h3000_000C, 32'h0A0B_0C0D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart2wb_master.md
# uart2wb_master

UART-to-Wishbone bridge master that sits directly upstream of `wb_host`: it receives byte-framed read/write commands on a serial line and issues single Wishbone classic transfers on the `wbm_*` slave port of `wb_host`. It gives lab boards and silicon bring-up a register-access path without a CPU. Each command produces exactly one bus transfer and one serial response.

## Interface
- `CLK_DIV`, 16: clocks per UART bit; integer ≥ 4; 8N1 framing.
- `WB_TIMEOUT`, 256: maximum cycles to wait for `ack`/`err` before aborting.
- `wbm_clk_i` in 1: single system clock.
- `wbm_rst_n` in 1: reset, asynchronous assert, active-low.
- `uart_rxd_i` in 1: serial input, idle high, asynchronous to the clock.
- `uart_txd_o` out 1: serial output, idle high.
- `wbm_cyc_o` out 1: bus cycle.
- `wbm_stb_o` out 1: strobe; always equal to `cyc`.
- `wbm_adr_o` out 32: byte address.
- `wbm_we_o` out 1: 1 = write.
- `wbm_dat_o` out 32: write data.
- `wbm_sel_o` out 4: byte enables; `4'hF` during a transfer, else 0.
- `wbm_dat_i` in 32: read data.
- `wbm_ack_i` in 1: transfer acknowledge.
- `wbm_err_i` in 1: transfer error.
- `busy_o` out 1: high from command completion until the response stop bit ends.

## Operation
- **Frames:**
  - Write: `0x57` ('W'), then 4 address bytes MSB first, then 4 data bytes MSB first.
  - Read: `0x52` ('R'), then 4 address bytes MSB first.
- **Responses:**
  - Write OK: `0x4B` ('K').
  - Read OK: 4 data bytes, MSB first.
  - Error or timeout: `0x45` ('E'), for either command type.
- **Parser FSM:** `IDLE → ADDR(4) → [DATA(4)] → BUS → RESP → IDLE`.
- **IDLE:** any byte other than W/R is silently dropped.
- **Framing error** (stop bit sampled 0): the byte is discarded and the parser returns to IDLE from any receive state.
- **Bytes arriving in BUS/RESP** are discarded. Only a single transaction is ever outstanding.
- **BUS:**
  - Assert `cyc/stb/sel` with `adr`, `we`, `dat` stable. Hold them until `ack`, `err`, or timeout.
  - Timeout counter is reset at BUS entry. It aborts when it reaches `WB_TIMEOUT` cycles with neither response.
  - `ack` and `err` asserted in the same cycle: `err` wins.
- **Read data** is captured from `wbm_dat_i` in the `ack` cycle.

## Timing
- **Reset values:** `uart_txd_o`=1; `cyc`, `stb`, `we`=0; `adr`, `dat`=0; `sel`=0; `busy_o`=0; FSM in IDLE; counters cleared.
- **Reset mid-operation** (bus or serial) forces all outputs to reset values immediately. There is no completion of the partial frame or response.
- **RX path:**
  - `uart_rxd_i` passes through a 2-flop synchronizer.
  - Start bit = high-to-low edge of the synchronized signal, re-checked low at `CLK_DIV/2`.
  - Data bits are sampled every `CLK_DIV` from that midpoint, LSB first, then the stop bit.
  - A byte is valid 1 cycle after the stop-bit sample.
- **Bus timing:**
  - `cyc` rises the cycle after the final payload byte is valid.
  - `cyc` falls the cycle after `ack`/`err` is sampled high, or the cycle after timeout.
  - A transfer therefore occupies ≥ 2 cycles.
- **TX timing:**
  - The response start bit begins ≤ 2 cycles after `cyc` falls.
  - Bytes are sent back-to-back; each is 10 × `CLK_DIV` cycles.
- **`busy_o`** rises with `cyc` and falls when the last stop bit completes.

## Structure
- **Package `uart2wb_pkg`:**
  - Command/response byte constants: `CMD_WR`=0x57, `CMD_RD`=0x52, `RSP_OK`=0x4B, `RSP_ERR`=0x45.
  - Parser state enum.
- **Sub-module `uart2wb_uart`:**
  - 8N1 RX with synchronizer, giving a `rx_data[7:0]`/`rx_valid` pulse and `rx_ferr`.
  - TX with `tx_data`/`tx_start`/`tx_busy`.
  - Parameterized by `CLK_DIV`.
- **Top level:** parser FSM, byte assembly shift registers, timeout counter, response sequencer.

## Test plan
1. Write: send W, `30000000`, `11223344` → one WB write with adr `0x3000_0000`, dat `0x11223344`, sel `F`; TX `0x4B`.
2. Read-back: send R, `30000000` → WB read; slave returns `0x11223344`; TX `0x11 0x22 0x33 0x44`. Repeat at `0x3000_0004` with `0x55667788`.
3. Timeout: read `0x4000_0000` with no `ack`/`err` → `cyc` drops after exactly 256 cycles; TX `0x45`.
4. Error: slave asserts `ack` and `err` in the same cycle → TX `0x45`. Bytes `0x00`, `0xFF` sent in IDLE → no bus activity.
5. Framing error: corrupt the stop bit on address byte 2, then send a clean W frame → only the clean write executes, with the correct address.
6. Reset mid-operation: drop `wbm_rst_n` with `cyc` high, and again during TX → outputs at reset values within the same cycle; a subsequent write succeeds.
